l2_prefetch_fill: RTL and testbench

//  Write-side engine for the L2 prefetch buffer. Fetches an aligned burst from the memory controller on a
//  CPU read miss and drives the buffer's write port (WRA/WRD/WR/WRM/CLR).

---
 rtl/l2_prefetch_pkg.sv | 31 +++
 rtl/l2_prefetch_snoop_hold.sv | 32 +++
 rtl/l2_prefetch_fill.sv | 245 ++++++++++++++++++++++++
 tb/tb_l2_prefetch_fill.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_prefetch_pkg.sv
// Shared types and constants for the L2 prefetch buffer fill engine.
package l2_prefetch_pkg;

   localparam int unsigned INDEX_W   = 7;
   localparam int unsigned LINE_W    = 26;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned MASK_W    = 4;
   localparam int unsigned FLUSH_CNT = 128;
   localparam logic [MASK_W-1:0] WRM_ALL = 4'b1111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MREQ,
      ST_FILL,
      ST_INVAL,
      ST_FLUSH
   } state_t;

   typedef struct packed {
      logic [LINE_W-1:0] a;
      logic [DATA_W-1:0] d;
      logic [MASK_W-1:0] m;
   } snoop_t;

   // Clear the in-line offset bits of a longword address.
   function automatic logic [LINE_W-1:0] line_align(input logic [LINE_W-1:0] a,
                                                    input int unsigned blen);
      return a & ~LINE_W'(blen - 1);
   endfunction

endpackage

// File: rtl/l2_prefetch_snoop_hold.sv
// One-entry holding register for a CPU write snoop that lost its write slot.
module l2_prefetch_snoop_hold
   import l2_prefetch_pkg::*;
(
   input  logic   i_clk,
   input  logic   i_rst_n,
   input  logic   i_load,
   input  logic   i_fwd,
   input  snoop_t i_snoop,
   output logic   o_full,
   output snoop_t o_snoop
);

   logic   r_full;
   snoop_t r_snoop;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_full  <= 1'b0;
         r_snoop <= '0;
      end else if (i_load) begin
         r_full  <= 1'b1;
         r_snoop <= i_snoop;
      end else if (i_fwd) begin
         r_full  <= 1'b0;
      end
   end

   assign o_full  = r_full;
   assign o_snoop = r_snoop;

endmodule

// File: rtl/l2_prefetch_fill.sv
// Write-side engine of the L2 prefetch buffer: burst fill, snoop forwarding, flush sweep.
// Optional next-line prefetch is enabled by defining PREFETCH_NEXTLINE_EN.
module l2_prefetch_fill
   import l2_prefetch_pkg::*;
#(
   parameter int unsigned BURST_LEN = 8
) (
   input  logic              CLK,
   input  logic              nRESET,
   input  logic              MissReq,
   input  logic [LINE_W-1:0] MissA,
   output logic              MissAck,
   output logic              Busy,
   output logic              MemReq,
   output logic [LINE_W-1:0] MemA,
   input  logic              MemGnt,
   input  logic              MemRDV,
   input  logic [DATA_W-1:0] MemRDD,
   input  logic              CPUWR,
   input  logic [LINE_W-1:0] CPUWRA,
   input  logic [DATA_W-1:0] CPUWRD,
   input  logic [MASK_W-1:0] CPUWRM,
   output logic              SnoopStall,
   input  logic              Flush,
   output logic [LINE_W-1:0] WRA,
   output logic [DATA_W-1:0] WRD,
   output logic              WR,
   output logic [MASK_W-1:0] WRM,
   output logic              CLR
);

   localparam logic [INDEX_W-1:0] LAST_BEAT  = INDEX_W'(BURST_LEN - 1);
   localparam logic [INDEX_W-1:0] LAST_SWEEP = INDEX_W'(FLUSH_CNT - 1);

   state_t              r_state, w_state_nx;
   logic [LINE_W-1:0]   r_base, w_base_nx;
   logic [INDEX_W-1:0]  r_cnt, w_cnt_nx;
   logic                r_poison, w_poison_nx;
   logic                r_flush_pend, w_flush_pend_nx;
`ifdef PREFETCH_NEXTLINE_EN
   logic                r_nl_arm, w_nl_arm_nx;
   logic                r_nl_fill, w_nl_fill_nx;
`endif

   logic                r_miss_ack, r_busy, r_mem_req, r_wr, r_clr;
   logic [LINE_W-1:0]   r_mem_a, r_wra;
   logic [DATA_W-1:0]   r_wrd;
   logic [MASK_W-1:0]   r_wrm;

   logic                w_miss_ack;
   logic                w_own_wr, w_own_clr;
   logic [LINE_W-1:0]   w_own_a;
   logic [DATA_W-1:0]   w_own_d;
   logic                w_hit;
   logic                w_hold_full, w_hold_load, w_fwd_hold, w_fwd_cpu;
   snoop_t              w_cpu_snoop, w_hold_snoop;
   logic                w_wr_nx, w_clr_nx;
   logic [LINE_W-1:0]   w_wra_nx;
   logic [DATA_W-1:0]   w_wrd_nx;
   logic [MASK_W-1:0]   w_wrm_nx;

   assign w_cpu_snoop = '{a: CPUWRA, d: CPUWRD, m: CPUWRM};

   l2_prefetch_snoop_hold u_hold (
      .i_clk   (CLK),
      .i_rst_n (nRESET),
      .i_load  (w_hold_load),
      .i_fwd   (w_fwd_hold),
      .i_snoop (w_cpu_snoop),
      .o_full  (w_hold_full),
      .o_snoop (w_hold_snoop)
   );

   // Next-state, own-write generation and write-port arbitration.
   always_comb begin
      w_state_nx      = r_state;
      w_base_nx       = r_base;
      w_cnt_nx        = r_cnt;
      w_poison_nx     = r_poison;
      w_flush_pend_nx = r_flush_pend;
`ifdef PREFETCH_NEXTLINE_EN
      w_nl_arm_nx     = r_nl_arm;
      w_nl_fill_nx    = r_nl_fill;
`endif
      w_miss_ack      = 1'b0;
      w_own_wr        = 1'b0;
      w_own_clr       = 1'b0;
      w_own_a         = '0;
      w_own_d         = '0;

      w_hit = CPUWR && ((r_state == ST_MREQ) || (r_state == ST_FILL)) &&
              (line_align(CPUWRA, BURST_LEN) == r_base);
      if (w_hit) w_poison_nx = 1'b1;
      if (Flush && (r_state != ST_IDLE) && (r_state != ST_FLUSH)) w_flush_pend_nx = 1'b1;

      case (r_state)
         ST_IDLE: begin
            if (r_flush_pend || Flush) begin
               w_state_nx      = ST_FLUSH;
               w_flush_pend_nx = 1'b0;
               w_cnt_nx        = '0;
            end else if (MissReq) begin
               w_miss_ack = 1'b1;
               w_base_nx  = line_align(MissA, BURST_LEN);
               w_state_nx = ST_MREQ;
`ifdef PREFETCH_NEXTLINE_EN
               w_nl_arm_nx  = 1'b0;
               w_nl_fill_nx = 1'b0;
            end else if (r_nl_arm) begin
               w_base_nx    = r_base + LINE_W'(BURST_LEN);
               w_state_nx   = ST_MREQ;
               w_nl_arm_nx  = 1'b0;
               w_nl_fill_nx = 1'b1;
`endif
            end
         end
         ST_MREQ: begin
            if (MemGnt) begin
               w_state_nx = ST_FILL;
               w_cnt_nx   = '0;
            end
         end
         ST_FILL: begin
            if (MemRDV) begin
               w_own_wr = 1'b1;
               w_own_a  = r_base + LINE_W'(r_cnt);
               w_own_d  = MemRDD;
               w_cnt_nx = r_cnt + INDEX_W'(1);
               if (r_cnt == LAST_BEAT) begin
                  w_cnt_nx = '0;
                  if (r_poison || w_hit) begin
                     w_state_nx = ST_INVAL;
                  end else begin
                     w_state_nx = ST_IDLE;
`ifdef PREFETCH_NEXTLINE_EN
                     w_nl_arm_nx = !r_nl_fill;
`endif
                  end
               end
            end
         end
         ST_INVAL: begin
            w_own_wr  = 1'b1;
            w_own_clr = 1'b1;
            w_own_a   = r_base + LINE_W'(r_cnt);
            w_cnt_nx  = r_cnt + INDEX_W'(1);
            if (r_cnt == LAST_BEAT) begin
               w_cnt_nx    = '0;
               w_poison_nx = 1'b0;
               w_state_nx  = ST_IDLE;
            end
         end
         ST_FLUSH: begin
            w_own_wr  = 1'b1;
            w_own_clr = 1'b1;
            w_own_a   = LINE_W'(r_cnt);
            w_cnt_nx  = r_cnt + INDEX_W'(1);
            if (r_cnt == LAST_SWEEP) begin
               w_cnt_nx   = '0;
               w_state_nx = ST_IDLE;
            end
         end
         default: w_state_nx = ST_IDLE;
      endcase

      // Own writes win the slot; a held snoop drains before a new one passes.
      w_fwd_hold  = w_hold_full && !w_own_wr;
      w_fwd_cpu   = CPUWR && !w_own_wr && !w_hold_full;
      w_hold_load = CPUWR && (w_own_wr || w_hold_full);

      w_wr_nx  = w_own_wr || w_fwd_hold || w_fwd_cpu;
      w_clr_nx = 1'b0;
      w_wra_nx = '0;
      w_wrd_nx = '0;
      w_wrm_nx = '0;
      if (w_own_wr) begin
         w_clr_nx = w_own_clr;
         w_wra_nx = w_own_a;
         w_wrd_nx = w_own_d;
         w_wrm_nx = WRM_ALL;
      end else if (w_fwd_hold) begin
         w_wra_nx = w_hold_snoop.a;
         w_wrd_nx = w_hold_snoop.d;
         w_wrm_nx = w_hold_snoop.m;
      end else if (w_fwd_cpu) begin
         w_wra_nx = CPUWRA;
         w_wrd_nx = CPUWRD;
         w_wrm_nx = CPUWRM;
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRESET) begin
         r_state      <= ST_IDLE;
         r_base       <= '0;
         r_cnt        <= '0;
         r_poison     <= 1'b0;
         r_flush_pend <= 1'b0;
`ifdef PREFETCH_NEXTLINE_EN
         r_nl_arm     <= 1'b0;
         r_nl_fill    <= 1'b0;
`endif
         r_miss_ack   <= 1'b0;
         r_busy       <= 1'b0;
         r_mem_req    <= 1'b0;
         r_mem_a      <= '0;
         r_wr         <= 1'b0;
         r_clr        <= 1'b0;
         r_wra        <= '0;
         r_wrd        <= '0;
         r_wrm        <= '0;
      end else begin
         r_state      <= w_state_nx;
         r_base       <= w_base_nx;
         r_cnt        <= w_cnt_nx;
         r_poison     <= w_poison_nx;
         r_flush_pend <= w_flush_pend_nx;
`ifdef PREFETCH_NEXTLINE_EN
         r_nl_arm     <= w_nl_arm_nx;
         r_nl_fill    <= w_nl_fill_nx;
`endif
         r_miss_ack   <= w_miss_ack;
         r_busy       <= (w_state_nx != ST_IDLE);
         r_mem_req    <= (w_state_nx == ST_MREQ);
         r_mem_a      <= (w_state_nx == ST_MREQ) ? w_base_nx : '0;
         r_wr         <= w_wr_nx;
         r_clr        <= w_clr_nx;
         r_wra        <= w_wra_nx;
         r_wrd        <= w_wrd_nx;
         r_wrm        <= w_wrm_nx;
      end
   end

   assign MissAck    = r_miss_ack;
   assign Busy       = r_busy;
   assign MemReq     = r_mem_req;
   assign MemA       = r_mem_a;
   assign SnoopStall = w_hold_full;
   assign WR         = r_wr;
   assign CLR        = r_clr;
   assign WRA        = r_wra;
   assign WRD        = r_wrd;
   assign WRM        = r_wrm;

endmodule

// File: tb/tb_l2_prefetch_fill.sv
// Scoreboard bench for l2_prefetch_fill: directed misses, snoops, flush and reset.
module tb_l2_prefetch_fill;

   logic        CLK = 1'b0;
   logic        nRESET = 1'b0;
   logic        MissReq = 1'b0;
   logic [25:0] MissA = '0;
   logic        MissAck, Busy, MemReq;
   logic [25:0] MemA;
   logic        MemGnt = 1'b0;
   logic        MemRDV = 1'b0;
   logic [31:0] MemRDD = '0;
   logic        CPUWR = 1'b0;
   logic [25:0] CPUWRA = '0;
   logic [31:0] CPUWRD = '0;
   logic [3:0]  CPUWRM = '0;
   logic        SnoopStall;
   logic        Flush = 1'b0;
   logic [25:0] WRA;
   logic [31:0] WRD;
   logic        WR;
   logic [3:0]  WRM;
   logic        CLR;

   typedef struct packed {
      logic        clr;
      logic [25:0] a;
      logic [31:0] d;
      logic [3:0]  m;
   } wr_t;

   typedef struct packed {
      logic        miss_ack;
      logic        busy;
      logic        mem_req;
      logic [25:0] mem_a;
      logic        wr;
      logic [25:0] wra;
      logic [31:0] wrd;
      logic [3:0]  wrm;
      logic        clr;
      logic        stall;
   } out_t;

   wr_t         wr_q[$];
   logic [25:0] req_q[$];
   int          ack_q[$];
   out_t        st_q[$];
   int          total = 0;
   int          bad = 0;
   bit          done = 1'b0;
   logic        prev_req = 1'b0;
   out_t        act;

   assign act = {MissAck, Busy, MemReq, MemA, WR, WRA, WRD, WRM, CLR, SnoopStall};

   l2_prefetch_fill #(.BURST_LEN(8)) dut (
      .CLK(CLK), .nRESET(nRESET),
      .MissReq(MissReq), .MissA(MissA), .MissAck(MissAck), .Busy(Busy),
      .MemReq(MemReq), .MemA(MemA), .MemGnt(MemGnt), .MemRDV(MemRDV), .MemRDD(MemRDD),
      .CPUWR(CPUWR), .CPUWRA(CPUWRA), .CPUWRD(CPUWRD), .CPUWRM(CPUWRM),
      .SnoopStall(SnoopStall), .Flush(Flush),
      .WRA(WRA), .WRD(WRD), .WR(WR), .WRM(WRM), .CLR(CLR)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Monitor: pops expectations whenever the DUT presents something.
   always @(negedge CLK) begin
      wr_t  e;
      out_t s;
      if (st_q.size() > 0) begin
         s = st_q.pop_front();
         total++;
         if (act !== s) begin
            bad++;
            $display("FAIL outputs: got %h want %h", act, s);
         end
      end
      if (WR === 1'b1) begin
         total++;
         if (wr_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected write: clr=%b a=%h d=%h m=%h", CLR, WRA, WRD, WRM);
         end else begin
            e = wr_q.pop_front();
            if ({CLR, WRA, WRD, WRM} !== e) begin
               bad++;
               $display("FAIL write: got clr=%b a=%h d=%h m=%h want clr=%b a=%h d=%h m=%h",
                        CLR, WRA, WRD, WRM, e.clr, e.a, e.d, e.m);
            end
         end
      end
      if (MemReq === 1'b1 && prev_req !== 1'b1) begin
         total++;
         if (req_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected MemReq: MemA=%h", MemA);
         end else if (MemA !== req_q[0]) begin
            bad++;
            $display("FAIL MemA: got %h want %h", MemA, req_q[0]);
            void'(req_q.pop_front());
         end else begin
            void'(req_q.pop_front());
         end
      end
      prev_req <= MemReq;
      if (MissAck === 1'b1) begin
         total++;
         if (ack_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected MissAck");
         end else begin
            void'(ack_q.pop_front());
            if ({Busy, MemReq} !== 2'b11) begin
               bad++;
               $display("FAIL ack state: got busy/memreq=%b want 11", {Busy, MemReq});
            end
         end
      end
      if (done) begin
         total++;
         if (wr_q.size() + req_q.size() + ack_q.size() + st_q.size() != 0) begin
            bad++;
            $display("FAIL leftover expectations: wr=%0d req=%0d ack=%0d st=%0d want 0",
                     wr_q.size(), req_q.size(), ack_q.size(), st_q.size());
         end
         $display("test done: total=%0d bad=%0d", total, bad);
         $finish;
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic exp_wr(input logic clr, input logic [25:0] a, input logic [31:0] d,
                         input logic [3:0] m);
      wr_q.push_back({clr, a, d, m});
   endtask

   task automatic check_out(input out_t e);
      st_q.push_back(e);
   endtask

   task automatic miss(input logic [25:0] addr, input logic [25:0] base);
      ack_q.push_back(1);
      req_q.push_back(base);
      MissReq = 1'b1;
      MissA   = addr;
      for (int i = 0; i < 20 && MissAck !== 1'b1; i++) tick();
      if (MissAck !== 1'b1) begin
         $display("FAIL MissAck timeout: got 0 want 1");
         $fatal(1, "timeout");
      end
      MissReq = 1'b0;
   endtask

   task automatic grant();
      for (int i = 0; i < 20 && MemReq !== 1'b1; i++) tick();
      if (MemReq !== 1'b1) begin
         $display("FAIL MemReq timeout: got 0 want 1");
         $fatal(1, "timeout");
      end
      MemGnt = 1'b1;
      tick();
      MemGnt = 1'b0;
   endtask

   task automatic beat(input logic [25:0] a, input logic [31:0] d, input int gap);
      exp_wr(1'b0, a, d, 4'hF);
      MemRDV = 1'b1;
      MemRDD = d;
      tick();
      MemRDV = 1'b0;
      MemRDD = '0;
      repeat (gap) tick();
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 400 && Busy !== 1'b0; i++) tick();
      if (Busy !== 1'b0) begin
         $display("FAIL Busy timeout: got 1 want 0");
         $fatal(1, "timeout");
      end
      tick();
   endtask

   // Next-line fill expected after a clean demand fill (only when the option is built in).
   task automatic exp_nl(input logic [25:0] nb);
`ifdef PREFETCH_NEXTLINE_EN
      req_q.push_back(nb);
`else
      if (nb == 26'h3FFFFFF) $display("note: unused line base");
`endif
   endtask

   task automatic follow_nl(input logic [25:0] nb);
`ifdef PREFETCH_NEXTLINE_EN
      grant();
      for (int i = 0; i < 8; i++) beat(nb + 26'(i), 32'h4E00_0000 | 32'(i), 0);
      wait_idle();
`else
      if (nb == 26'h3FFFFFF) $display("note: unused line base");
`endif
   endtask

   initial begin
      out_t e;

      // Reset state
      repeat (2) tick();
      check_out('0);
      tick();
      nRESET = 1'b1;
      tick();
      check_out('0);

      // Demand fill, back-to-back beats
      miss(26'h0000123, 26'h0000120);
      exp_nl(26'h0000128);
      grant();
      for (int i = 0; i < 8; i++) beat(26'h0000120 + 26'(i), 32'hD000_0000 | 32'(i), 0);
      wait_idle();
      follow_nl(26'h0000128);
      check_out('0);

      // Snoop in IDLE forwards next cycle
      CPUWR = 1'b1; CPUWRA = 26'h0000777; CPUWRD = 32'h1234_5678; CPUWRM = 4'b1000;
      exp_wr(1'b0, 26'h0000777, 32'h1234_5678, 4'b1000);
      tick();
      CPUWR = 1'b0;
      e = '0; e.wr = 1'b1; e.wra = 26'h0000777; e.wrd = 32'h1234_5678; e.wrm = 4'b1000;
      check_out(e);
      tick();

      // Fill with 3-cycle gaps between beats
      miss(26'h0000456, 26'h0000450);
      exp_nl(26'h0000458);
      grant();
      for (int i = 0; i < 8; i++) beat(26'h0000450 + 26'(i), 32'hA5A5_0000 | 32'(i), 3);
      wait_idle();
      follow_nl(26'h0000458);
      check_out('0);

      // Snoop collides with beat 3, then poisoned line is invalidated
      miss(26'h0000127, 26'h0000120);
      grant();
      for (int i = 0; i < 3; i++) beat(26'h0000120 + 26'(i), 32'hB000_0000 | 32'(i), 0);
      CPUWR = 1'b1; CPUWRA = 26'h0000124; CPUWRD = 32'hCAFE_F00D; CPUWRM = 4'b0011;
      beat(26'h0000123, 32'hB000_0003, 0);
      exp_wr(1'b0, 26'h0000124, 32'hCAFE_F00D, 4'b0011);
      CPUWR = 1'b0;
      e = '0; e.busy = 1'b1; e.wr = 1'b1; e.wra = 26'h0000123; e.wrd = 32'hB000_0003;
      e.wrm = 4'hF; e.stall = 1'b1;
      check_out(e);
      tick();
      for (int i = 4; i < 8; i++) beat(26'h0000120 + 26'(i), 32'hB000_0000 | 32'(i), 0);
      for (int i = 0; i < 8; i++) exp_wr(1'b1, 26'h0000120 + 26'(i), 32'h0, 4'hF);
      wait_idle();
      check_out('0);

      // Flush during fill: fill completes, then full sweep; second pulse ignored
      miss(26'h0000200, 26'h0000200);
      exp_nl(26'h0000208);
      grant();
      for (int i = 0; i < 4; i++) beat(26'h0000200 + 26'(i), 32'hC000_0000 | 32'(i), 0);
      Flush = 1'b1;
      tick();
      Flush = 1'b0;
      for (int i = 4; i < 8; i++) beat(26'h0000200 + 26'(i), 32'hC000_0000 | 32'(i), 0);
      for (int i = 0; i < 128; i++) exp_wr(1'b1, 26'(i), 32'h0, 4'hF);
      repeat (10) tick();
      Flush = 1'b1;
      tick();
      Flush = 1'b0;
      wait_idle();
      follow_nl(26'h0000208);
      repeat (3) tick();
      check_out('0);

      // Reset in the middle of a fill
      miss(26'h0000300, 26'h0000300);
      grant();
      for (int i = 0; i < 3; i++) beat(26'h0000300 + 26'(i), 32'hE000_0000 | 32'(i), 0);
      nRESET = 1'b0;
      tick();
      nRESET = 1'b1;
      check_out('0);
      MemRDV = 1'b1;
      MemRDD = 32'hDEAD_BEEF;
      repeat (5) tick();
      MemRDV = 1'b0;
      MemRDD = '0;
      tick();
      check_out('0);

      // Line at the top of the address space; next line wraps to 0
      miss(26'h3FFFFFA, 26'h3FFFFF8);
      exp_nl(26'h0000000);
      grant();
      for (int i = 0; i < 8; i++) beat(26'h3FFFFF8 + 26'(i), 32'hF000_0000 | 32'(i), 0);
      wait_idle();
      follow_nl(26'h0000000);
      repeat (2) tick();
      check_out('0);
      tick();
      done = 1'b1;
   end

endmodule
